// File: rtl/da_rom_loader.sv
// Coefficient-to-ROM programmer for the da FIR core: holds 64 taps and streams
// all 2048 distributed-arithmetic partial sums, one per clock, on the load port.

module da_rom_lane #(
  parameter int COEF_W = 16
) (
  input  logic              sel,
  input  logic [COEF_W-1:0] tap,
  output logic [COEF_W-1:0] pp
);
  assign pp = sel ? tap : '0;
endmodule

module da_rom_loader #(
  parameter int COEF_W = 16,
  parameter int CIN_W  = 20
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              coef_we,
  input  logic [5:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              start_load,
  input  logic              abort,
  output logic [10:0]       CADDR,
  output logic [CIN_W-1:0]  CIN,
  output logic              CLOAD,
  output logic              CVALID,
  output logic              busy,
  output logic              done
);
  localparam int SUM_W = COEF_W + 3;

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  state_e                       state_q, state_d;
  // cnt[11] marks that word 2047 has already been registered
  logic [11:0]                  cnt_q, cnt_d;
  logic [7:0][7:0][COEF_W-1:0]  taps_q, taps_d;
  logic [10:0]                  caddr_q, caddr_d;
  logic [CIN_W-1:0]             cin_q, cin_d;
  logic                         cload_q, cload_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic [7:0][COEF_W-1:0]       pp;
  logic signed [SUM_W-1:0]      sum;

  // One lane per address bit; lane b selects tap 8k+b of the current ROM k.
  for (genvar b = 0; b < 8; b++) begin : g_lane
    da_rom_lane #(.COEF_W(COEF_W)) u_lane (
      .sel (cnt_q[b]),
      .tap (taps_q[cnt_q[10:8]][b]),
      .pp  (pp[b])
    );
  end

  always_comb begin
    sum = '0;
    for (int b = 0; b < 8; b++) sum = sum + SUM_W'($signed(pp[b]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    taps_d  = taps_q;
    caddr_d = caddr_q;
    cin_d   = cin_q;
    cload_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q == S_IDLE && coef_we)
      taps_d[coef_addr[5:3]][coef_addr[2:0]] = coef_data;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start_load && !abort) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q[11]) begin
          // Finish edge; a held start_load restarts here so loads are one idle cycle apart.
          done_d = 1'b1;
          cnt_d  = '0;
          if (start_load) begin
            state_d = S_LOAD;
            busy_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          caddr_d = cnt_q[10:0];
          cin_d   = CIN_W'(sum);
          cload_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = cnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      taps_q  <= '0;
      caddr_q <= '0;
      cin_q   <= '0;
      cload_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      cload_q <= cload_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign CADDR  = caddr_q;
  assign CIN    = cin_q;
  assign CLOAD  = cload_q;
  assign CVALID = cload_q;
  assign busy   = busy_q;
  assign done   = done_q;
endmodule
